cla_seq_adder: RTL and testbench
================================

# cla_seq_adder

Multi-cycle WIDTH-bit adder controller that time-shares a single 4-bit carry-lookahead slice across all nibbles of its operands. It latches operands on a start handshake, walks the nibbles from least to most significant, and registers the sum and carry chain one nibble per clock. It then pulses done. It sits beside the ALU as the area-reduced add path for wide operands.

## Interface

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on the accepting edge.
- b  input  WIDTH  operand B; latched on the accepting edge.
- ci  input  1  carry-in; latched on the accepting edge.
- sub  input  1  subtract select; present only with CLA_SEQ_SUB_EN; latched on the accepting edge.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- s  output  WIDTH  registered sum.
- co  output  1  registered final carry-out.

## Operation

- State machine: IDLE, RUN, DONE, 2-bit encoded.
- IDLE:
  - start=1 at a rising edge: latch a into ra and b into rb, load carry register cr with the carry-in, clear nibble counter cnt (log2(N) bits), clear s and co, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Slice inputs: ra[4cnt+3:4cnt], rb[4cnt+3:4cnt], cr.
  - The slice uses generate/propagate form (g=a&b, p=a|b) and returns c1, c2, c3 and the carry-out.
  - Nibble sum = a_nib ^ b_nib ^ {c3,c2,c1,cr}.
  - Write the nibble sum into s[4cnt+3:4cnt]; set cr to the slice carry-out; increment cnt.
  - When cnt == N-1: also load co with the slice carry-out and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing.
- s and co hold their values from the end of RUN until the next accepted start, which clears them.
- Only ra, rb and cr are used during RUN, so a and b may change freely after acceptance.
- Arithmetic: s = (a + b + ci) mod 2^WIDTH; co is bit WIDTH of the full sum.
- The slice is purely combinational; the block adds no pipelining inside the slice.
- Asynchronous reset, including mid-RUN: state=IDLE, cnt=0, ra=rb=0, cr=0. The in-progress operation is discarded.

## Timing

- Reset values: busy=0, done=0, s=0, co=0.
- Acceptance edge E0: busy rises after E0.
- Nibble k is written at edge E(k+1), for k = 0..N-1.
- DONE is entered at edge EN; done is high and busy is low for the cycle after EN; co is valid at the same time.
- Latency from the accepting edge to done is N cycles (8 for WIDTH=32).
- Throughput: one operation per N+2 cycles. The earliest next acceptance is the edge that ends the done cycle plus one IDLE edge, because start is sampled only in IDLE.
- busy and done are never high together.
- Critical path: nibble mux, then slice, then sum XOR, then register. It is independent of WIDTH apart from the mux depth.

## Configuration

- CLA_SEQ_SUB_EN defined:
  - The sub port exists.
  - When sub=1 at acceptance: rb = ~b and cr = 1, ignoring ci. The result is s = a - b mod 2^WIDTH, with co=1 meaning no borrow.
  - When sub=0: plain addition.
- CLA_SEQ_SUB_EN undefined: no sub port; rb = b and cr = ci always.

## Test plan

All cases use WIDTH=32.
- Carry ripple: a=0xFFFFFFFF, b=0x00000001, ci=0, start pulse -> done exactly 8 cycles after the accepting edge; s=0x00000000, co=1; busy high for 8 cycles.
- Carry-in: a=0x12345678, b=0x11111111, ci=1 -> s=0x2345678A, co=0.
- Start ignored while busy: start held high through RUN and DONE with new operands -> the first result is unchanged, exactly one done pulse, and the second operation is accepted only on the following IDLE edge.
- Mid-operation reset: reset_n low at RUN cycle 4 -> immediately busy=0, done=0, s=0, co=0. After release, with no start, no done ever appears. A fresh a=3, b=4 -> s=7.
- Subtraction, CLA_SEQ_SUB_EN defined only: sub=1, a=5, b=7 -> s=0xFFFFFFFE, co=0. Then sub=1, a=7, b=5 -> s=2, co=1.
- Result hold: after done, change a and b with no start for 20 cycles -> s and co stay stable.

Source files
------------

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder that reuses one 4-bit carry-lookahead slice.
// It processes one nibble per clock, from the least significant nibble up.
// Optional build macro CLA_SEQ_SUB_EN adds the sub port for a - b.
// WIDTH must be a multiple of 4 and at least 8.

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);
  logic [3:0] g, p;
  logic       c1, c2, c3;

  // generate/propagate lookahead; all carries are flat two-level terms
  always_comb begin
    g  = a & b;
    p  = a | b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    sum = a ^ b ^ {c3, c2, c1, ci};
  end
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [N-1:0][3:0]  ra, rb, sq;
  logic               cr;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   b_eff;
  logic               ci_eff;
  logic [3:0]         nib_sum;
  logic               nib_co;
  logic               last;

  // operand conditioning at acceptance: subtract is a + ~b + 1
`ifdef CLA_SEQ_SUB_EN
  always_comb begin
    b_eff  = sub ? ~b : b;
    ci_eff = sub ? 1'b1 : ci;
  end
`else
  always_comb begin
    b_eff  = b;
    ci_eff = ci;
  end
`endif

  // the single shared slice, fed by the nibble selected by cnt
  cla4_slice u_slice (
    .a   (ra[cnt]),
    .b   (rb[cnt]),
    .ci  (cr),
    .sum (nib_sum),
    .co  (nib_co)
  );

  assign last = (cnt == CW'(N - 1));
  assign s    = sq;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: latch operands on accept, then write one nibble per RUN cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra  <= '0;
      rb  <= '0;
      cr  <= 1'b0;
      cnt <= '0;
      sq  <= '0;
      co  <= 1'b0;
    end else if (state == IDLE && start) begin
      ra  <= a;
      rb  <= b_eff;
      cr  <= ci_eff;
      cnt <= '0;
      sq  <= '0;
      co  <= 1'b0;
    end else if (state == RUN) begin
      sq[cnt] <= nib_sum;
      cr      <= nib_co;
      cnt     <= cnt + 1'b1;
      if (last) co <= nib_co;
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at WIDTH=32.
module tb_cla_seq_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        co;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ci = 1'b0;
  logic        sub_r = 1'b0;
  logic        busy, done, co;
  logic [31:0] s;

  int   n_chk = 0, n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ci      (ci),
`ifdef CLA_SEQ_SUB_EN
    .sub     (sub_r),
`endif
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mci, input logic msub);
    logic [32:0] t;
`ifdef CLA_SEQ_SUB_EN
    if (msub) t = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
    else      t = {1'b0, ma} + {1'b0, mb} + {32'd0, mci};
`else
    t = {1'b0, ma} + {1'b0, mb} + {32'd0, mci} + 33'(msub & 1'b0);
`endif
    return '{s: t[31:0], co: t[32]};
  endfunction

  // compare every done pulse against the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset_n && done) begin
      chk("busy_done_excl", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) chk("done_unexpected", {63'd0, done}, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", {32'd0, s}, {32'd0, e.s});
        chk("carry", {63'd0, co}, {63'd0, e.co});
      end
    end
  end

  // after the accepting edge (+#1): wait for done and check timing
  task automatic wait_done();
    int k, nb;
    nb = 0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("latency", 64'(k - 1), 64'd8);
    chk("busy_cycles", 64'(nb), 64'd8);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tci,
                        input logic tsub);
    @(negedge clk);
    a = ta; b = tb_; ci = tci; sub_r = tsub; start = 1'b1;
    sb.push_back(model(ta, tb_, tci, tsub));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; ci = ~ci;   // operands are latched; scramble inputs
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [31:0] hs;
    logic        hc;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_s", {32'd0, s}, 64'd0);
    chk("rst_co", {63'd0, co}, 64'd0);
    reset_n = 1'b1;

    // carry ripple and carry-in
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    chk("cin_s_direct", {32'd0, s}, 64'h2345_678A);

    // random operands
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);

    // start held high through RUN and DONE with new operands
    @(negedge clk);
    a = 32'h0000_00F0; b = 32'h0000_0010; ci = 1'b0; sub_r = 1'b0; start = 1'b1;
    sb.push_back(model(32'h0000_00F0, 32'h0000_0010, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    a = 32'hDEAD_0000; b = 32'h0000_BEEF; ci = 1'b1;
    wait_done();
    sb.push_back(model(32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    chk("idle_gap_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    chk("second_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    wait_done();

    // mid-operation reset
    @(negedge clk);
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; ci = 1'b1; start = 1'b1;
    sb.push_back(model(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    chk("mrst_s", {32'd0, s}, 64'd0);
    chk("mrst_co", {63'd0, co}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", 64'(nd), 64'd0);
    run_op(32'd3, 32'd4, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1);
    chk("sub_neg_s", {32'd0, s}, 64'hFFFF_FFFE);
    run_op(32'd7, 32'd5, 1'b0, 1'b1);
    chk("sub_pos_s", {32'd0, s}, 64'd2);
    run_op(32'd9, 32'd1, 1'b1, 1'b0);
`endif

    // result hold with inputs changing and no start
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0);
    hs = 32'h0000_0000;
    hc = 1'b1;
    repeat (20) begin
      @(negedge clk);
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
    end
    chk("hold_s", {32'd0, s}, {32'd0, hs});
    chk("hold_co", {63'd0, co}, {63'd0, hc});
    chk("hold_busy", {63'd0, busy}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
